led_sequencer: RTL and testbench



---
 rtl/led_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_led_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: per-channel LED mode controller for two board LEDs
// (ch0 = red, ch1 = green). Commands arrive over a valid/ready handshake,
// are held for one clock in a pending register, then applied to the target
// channel. Each channel runs OFF / ON / BLINK / BURST timing from a shared
// millisecond-scale prescaler tick.
module led_sequencer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 12,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_chan,
  input  logic [1:0]       cmd_mode,
  input  logic [PER_W-1:0] cmd_half,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [1:0]       en,
  output logic [1:0]       led_out,
  output logic [1:0]       busy,
  output logic [1:0]       done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ON  = 2'd1,
    S_HI  = 2'd2,
    S_LO  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] r_presc;
  logic             w_tick;

  assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));

  // Free-running timebase; commands never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Command stage: one pending slot, applied on the following edge
  // ---------------------------------------------------------------------
  logic             r_pend_valid;
  logic             r_pend_chan;
  logic [1:0]       r_pend_mode;
  logic [PER_W-1:0] r_pend_half;
  logic [CNT_W-1:0] r_pend_count;
  logic             w_accept;

  assign cmd_ready = ~r_pend_valid;
  assign w_accept  = cmd_valid & ~r_pend_valid;

  // Capture an accepted command; the slot empties itself one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_chan  <= 1'b0;
      r_pend_mode  <= MODE_OFF;
      r_pend_half  <= '0;
      r_pend_count <= '0;
    end else begin
      r_pend_valid <= w_accept;
      if (w_accept) begin
        r_pend_chan  <= cmd_chan;
        r_pend_mode  <= cmd_mode;
        r_pend_half  <= cmd_half;
        r_pend_count <= cmd_count;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel FSMs
  // ---------------------------------------------------------------------
  logic [1:0] w_led_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      state_t           r_state,  w_state_next;
      logic [PER_W-1:0] r_phase,  w_phase_next;
      logic [PER_W-1:0] r_half,   w_half_next;
      logic [CNT_W-1:0] r_flash,  w_flash_next;
      logic             r_burst,  w_burst_next;
      logic             r_done,   w_done_next;
      logic             w_apply;
      logic             w_last;

      assign w_apply = r_pend_valid && (r_pend_chan == 1'(gi));
      // r_half is never 0, so half-1 cannot wrap.
      assign w_last  = (r_phase == (r_half - 1'b1));

      // Channel state register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= S_OFF;
          r_phase <= '0;
          r_half  <= PER_W'(1);
          r_flash <= '0;
          r_burst <= 1'b0;
          r_done  <= 1'b0;
        end else begin
          r_state <= w_state_next;
          r_phase <= w_phase_next;
          r_half  <= w_half_next;
          r_flash <= w_flash_next;
          r_burst <= w_burst_next;
          r_done  <= w_done_next;
        end
      end

      // Next state: a command apply overrides any tick-driven transition.
      always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_half_next  = r_half;
        w_flash_next = r_flash;
        w_burst_next = r_burst;
        w_done_next  = 1'b0;

        if (w_apply) begin
          w_phase_next = '0;
          w_flash_next = r_pend_count;
          w_half_next  = (r_pend_half == '0) ? PER_W'(1) : r_pend_half;
          w_burst_next = 1'b0;
          case (r_pend_mode)
            MODE_OFF:   w_state_next = S_OFF;
            MODE_ON:    w_state_next = S_ON;
            MODE_BLINK: w_state_next = S_HI;
            MODE_BURST: begin
              if (r_pend_count != '0) begin
                w_state_next = S_HI;
                w_burst_next = 1'b1;
              end else begin
                // Empty burst completes immediately.
                w_state_next = S_OFF;
                w_done_next  = 1'b1;
              end
            end
            default:    w_state_next = S_OFF;
          endcase
        end else if (w_tick && ((r_state == S_HI) || (r_state == S_LO))) begin
          if (w_last) begin
            w_phase_next = '0;
            if (r_state == S_HI) begin
              w_state_next = S_LO;
            end else if (r_burst && (r_flash == CNT_W'(1))) begin
              // Last flash's off-time has elapsed: burst finished.
              w_flash_next = '0;
              w_state_next = S_OFF;
              w_burst_next = 1'b0;
              w_done_next  = 1'b1;
            end else begin
              if (r_burst) begin
                w_flash_next = r_flash - 1'b1;
              end
              w_state_next = S_HI;
            end
          end else begin
            w_phase_next = r_phase + 1'b1;
          end
        end
      end

      assign w_led_q[gi] = (r_state == S_ON) || (r_state == S_HI);
      assign busy[gi]    = r_burst;
      assign done[gi]    = r_done;
    end
  endgenerate

  assign led_out = w_led_q & en;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed + randomized command traffic. A reference model
// computes each channel's expected output from the apply edge and elapsed
// ticks in closed form and queues one expectation per clock; an independent
// monitor pops and compares against the DUT.
module tb_led_sequencer;

  localparam int PER_W = 12;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_chan = 1'b0;
  logic [1:0]       cmd_mode = 2'b00;
  logic [PER_W-1:0] cmd_half = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [1:0]       en = 2'b00;
  logic [1:0]       led_out;
  logic [1:0]       busy;
  logic [1:0]       done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] busy;
    logic [1:0] done;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  led_sequencer #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .PER_W  (PER_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_chan (cmd_chan),
    .cmd_mode (cmd_mode),
    .cmd_half (cmd_half),
    .cmd_count(cmd_count),
    .en       (en),
    .led_out  (led_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  // Expected channel output at edge kk, given the mode applied at edge a.
  // Ticks land on edges that are multiples of 10 (counted from reset
  // release); a tick on the apply edge itself is not counted. The j-th
  // HI/LO swap happens on the (j*h)-th tick after the apply edge.
  function automatic void eval(input int mode, input int a, input int h,
                               input int cnt, input int kk,
                               output logic led, output logic bsy,
                               output logic dn);
    int t1;
    int j;
    led = 1'b0;
    bsy = 1'b0;
    dn  = 1'b0;
    case (mode)
      1: led = 1'b1;
      2, 3: begin
        if (mode == 3 && cnt == 0) begin
          dn = (kk == a);
        end else begin
          t1 = (a / 10 + 1) * 10;
          j  = (kk < t1) ? 0 : (((kk - t1) / 10 + 1) / h);
          if (mode == 3 && j >= 2 * cnt) begin
            dn = (kk == t1 + (2 * cnt * h - 1) * 10);
          end else begin
            led = (j % 2 == 0);
            bsy = (mode == 3);
          end
        end
      end
      default: led = 1'b0;
    endcase
  endfunction

  // Reference model: one expectation per clock edge.
  initial begin : model
    int   k;
    bit   pend_v;
    int   pend_ch, pend_mode, pend_half, pend_cnt;
    int   m_mode[2], m_a[2], m_h[2], m_cnt[2];
    exp_t e;
    logic l, b, d;
    k = 0;
    pend_v = 0;
    pend_ch = 0; pend_mode = 0; pend_half = 0; pend_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = 0; m_a[c] = 0; m_h[c] = 1; m_cnt[c] = 0;
    end
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        k = 0;
        pend_v = 0;
        for (int c = 0; c < 2; c++) m_mode[c] = 0;
        e.ready = 1'b1;
      end else begin
        k++;
        if (pend_v) begin
          m_mode[pend_ch] = pend_mode;
          m_a[pend_ch]    = k;
          m_h[pend_ch]    = (pend_half == 0) ? 1 : pend_half;
          m_cnt[pend_ch]  = pend_cnt;
        end
        if (cmd_valid && !pend_v) begin
          pend_v    = 1;
          pend_ch   = int'(cmd_chan);
          pend_mode = int'(cmd_mode);
          pend_half = int'(cmd_half);
          pend_cnt  = int'(cmd_count);
        end else begin
          pend_v = 0;
        end
        e.ready = !pend_v;
        for (int c = 0; c < 2; c++) begin
          eval(m_mode[c], m_a[c], m_h[c], m_cnt[c], k, l, b, d);
          e.led[c]  = l & en[c];
          e.busy[c] = b;
          e.done[c] = d;
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs shortly after each active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("led_out",   int'(led_out),   int'(e.led));
        check("busy",      int'(busy),      int'(e.busy));
        check("done",      int'(done),      int'(e.done));
        check("cmd_ready", int'(cmd_ready), int'(e.ready));
      end
    end
  end

  // Present a command (call at a negedge); returns at the negedge after
  // the accepting edge. With hold set, cmd_valid stays high for the next one.
  task automatic send(input logic ch, input logic [1:0] mode, input int half,
                      input int cnt, input bit hold);
    cmd_chan  = ch;
    cmd_mode  = mode;
    cmd_half  = PER_W'(half);
    cmd_count = CNT_W'(cnt);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        $display("cmd ch%0d mode=%0d half=%0d count=%0d accepted @%0t",
                 ch, mode, half, cnt, $time);
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    int gap;
    idle(3);
    rst = 1'b0;
    en  = 2'b11;
    idle(100);

    // Continuous blink on green.
    send(1'b1, 2'b10, 3, 0, 1'b0);
    idle(200);
    send(1'b1, 2'b00, 0, 0, 1'b0);

    // Three-flash burst on red.
    send(1'b0, 2'b11, 2, 3, 1'b0);
    idle(200);

    // Abort a long burst, then an empty burst.
    send(1'b0, 2'b11, 5, 10, 1'b0);
    idle(50);
    send(1'b0, 2'b00, 0, 0, 1'b0);
    idle(20);
    send(1'b0, 2'b11, 4, 0, 1'b0);
    idle(20);

    // Back-to-back commands with cmd_valid held high.
    send(1'b1, 2'b10, 1, 0, 1'b1);
    send(1'b0, 2'b01, 0, 0, 1'b1);
    send(1'b1, 2'b10, 2, 0, 1'b0);
    idle(40);
    en = 2'b01;
    idle(80);
    en = 2'b11;

    // Reset in the middle of blinking on both channels.
    send(1'b0, 2'b10, 2, 0, 1'b0);
    idle(37);
    rst = 1'b1;
    #1;
    check("rst_led_out",   int'(led_out),   0);
    check("rst_busy",      int'(busy),      0);
    check("rst_done",      int'(done),      0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    idle(3);
    rst = 1'b0;
    idle(5);
    send(1'b1, 2'b10, 3, 0, 1'b0);
    idle(100);

    // Randomized traffic, including bursts colliding with new commands.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) en = 2'($urandom_range(0, 3));
      gap = (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60)));
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), gap == 0);
      idle(gap);
    end
    idle(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
